// File: rtl/dmem_debug_sequencer.sv
// Data-memory port arbiter for the MEM stage: forwards pipeline accesses, or,
// when the pipeline is halted for debug, reads DEPTH words and streams them out.
module dmem_debug_sequencer #(
  parameter int unsigned DEPTH     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [1:0]  LEN_WORD  = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_halted,
  input  logic        dump_req,
  input  logic [1:0]  pipe_mem_ctrl,
  input  logic [31:0] pipe_addr,
  input  logic [31:0] pipe_wdata,
  input  logic [1:0]  pipe_length,
  output logic [1:0]  mem_ctrl,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_length,
  input  logic [31:0] mem_rdata,
  output logic [31:0] out_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic        abort
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  localparam logic [1:0] CTRL_IDLE  = 2'b00;
  localparam logic [1:0] CTRL_WRITE = 2'b01;
  localparam logic [1:0] CTRL_READ  = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    SEND,
    FINISH
  } state_t;

  state_t           state, stateNext;
  logic [IDX_W-1:0] idx, idxNext;
  logic [31:0]      outWordNext;
  logic             outValidNext;
  logic             abortNext;
  logic [31:0]      dumpAddr;

  // 32-bit modulo sum: wrapping past the top of the address space is allowed.
  assign dumpAddr = BASE_ADDR + (32'(idx) << 2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      out_word  <= '0;
      out_valid <= 1'b0;
      abort     <= 1'b0;
    end else begin
      state     <= stateNext;
      idx       <= idxNext;
      out_word  <= outWordNext;
      out_valid <= outValidNext;
      abort     <= abortNext;
    end
  end

  // Memory port mux: pass-through only in IDLE, sequencer owns it otherwise.
  always_comb begin
    mem_ctrl   = CTRL_IDLE;
    mem_addr   = dumpAddr;
    mem_wdata  = '0;
    mem_length = LEN_WORD;
    if (state == IDLE) begin
      mem_ctrl   = (pipe_mem_ctrl == CTRL_WRITE || pipe_mem_ctrl == CTRL_READ)
                   ? pipe_mem_ctrl : CTRL_IDLE;
      mem_addr   = pipe_addr;
      mem_wdata  = pipe_wdata;
      mem_length = pipe_length;
    end else if (state == ISSUE) begin
      mem_ctrl = CTRL_READ;
    end
  end

  always_comb begin
    stateNext    = state;
    idxNext      = idx;
    outWordNext  = out_word;
    outValidNext = out_valid;
    abortNext    = 1'b0;
    busy         = (state != IDLE);
    done         = (state == FINISH);

    // Losing the halt cancels the dump from any busy state, ahead of any handshake.
    if (state != IDLE && !pipe_halted) begin
      stateNext    = IDLE;
      idxNext      = '0;
      outValidNext = 1'b0;
      abortNext    = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (dump_req) begin
            if (pipe_halted) begin
              idxNext   = '0;
              stateNext = ISSUE;
            end else begin
              abortNext = 1'b1;
            end
          end
        end
        ISSUE: begin
          stateNext = CAPTURE;
        end
        CAPTURE: begin
          outWordNext  = mem_rdata;
          outValidNext = 1'b1;
          stateNext    = SEND;
        end
        SEND: begin
          if (out_ready) begin
            outValidNext = 1'b0;
            if (idx == LAST_IDX) begin
              stateNext = FINISH;
            end else begin
              idxNext   = idx + 1'b1;
              stateNext = ISSUE;
            end
          end
        end
        FINISH: begin
          idxNext   = '0;
          stateNext = IDLE;
        end
        default: begin
          stateNext    = IDLE;
          idxNext      = '0;
          outValidNext = 1'b0;
        end
      endcase
    end
  end

endmodule
